pixel_serializer: RTL

Serializes the frame grabber's wide multi-pixel stream into one pixel per beat, with row/column coordinates attached to each pixel. It produces the pixel stream, coordinates and frame-level ap handshakes consumed by the crop/normalize stage. It sits between the CoaxLink pixel stream and the crop/normalize stage, and handles one frame per ap_start.

---
 rtl/pixel_serializer_pkg.sv | 32 +++
 rtl/pixel_serializer_unpacker.sv | 71 +++++++
 rtl/pixel_serializer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pixel_serializer_pkg.sv
// rtl/pixel_serializer_pkg.sv - shared state type and width helpers for pixel_serializer.
package pixel_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    STREAM   = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Widths never collapse below one bit so degenerate sizes still elaborate.
  function automatic int min1_clog2(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

  function automatic int word_w(input int pixel_bit_width, input int pixels_per_burst);
    return pixel_bit_width * pixels_per_burst;
  endfunction

  function automatic int lane_w(input int pixels_per_burst);
    return min1_clog2(pixels_per_burst);
  endfunction

  function automatic int col_w(input int in_cols);
    return min1_clog2(in_cols);
  endfunction

  function automatic int row_w(input int in_rows);
    return min1_clog2(in_rows);
  endfunction

endpackage

// File: rtl/pixel_serializer_unpacker.sv
// rtl/pixel_serializer_unpacker.sv - one-word buffer that emits its lanes one pixel per handshake.
module burst_unpacker
  import pixel_serializer_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH  = 8,
  parameter int PIXELS_PER_BURST = 4
) (
  input  logic                                                  clk,
  input  logic                                                  srst,
  input  logic                                                  wait_sof_i,
  input  logic                                                  stream_en_i,
  input  logic                                                  s_tvalid_i,
  input  logic [word_w(PIXEL_BIT_WIDTH, PIXELS_PER_BURST)-1:0]  s_tdata_i,
  input  logic                                                  s_tuser_i,
  output logic                                                  s_tready_o,
  output logic                                                  m_tvalid_o,
  input  logic                                                  m_tready_i,
  output logic [PIXEL_BIT_WIDTH-1:0]                            m_tdata_o,
  output logic                                                  load_o,
  output logic                                                  m_fire_o
);

  localparam int WORD_W = word_w(PIXEL_BIT_WIDTH, PIXELS_PER_BURST);
  localparam int LANE_W = lane_w(PIXELS_PER_BURST);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIXELS_PER_BURST - 1);

  logic [WORD_W-1:0] word_q, word_d;
  logic              full_q, full_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              last_lane;

  assign last_lane  = (lane_q == LAST_LANE);
  // While hunting for SOF every word is taken so non-SOF words can be dropped.
  assign s_tready_o = wait_sof_i ? 1'b1
                    : (stream_en_i && (!full_q || (m_tready_i && last_lane)));
  assign load_o     = s_tvalid_i && s_tready_o && (!wait_sof_i || s_tuser_i);
  assign m_fire_o   = full_q && m_tready_i;
  assign m_tvalid_o = full_q;
  assign m_tdata_o  = word_q[lane_q*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];

  always_comb begin
    word_d = word_q;
    full_d = full_q;
    lane_d = lane_q;
    if (load_o) begin
      word_d = s_tdata_i;
      full_d = 1'b1;
      lane_d = '0;
    end else if (m_fire_o) begin
      if (last_lane) begin
        full_d = 1'b0;
        lane_d = '0;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      word_q <= '0;
      full_q <= 1'b0;
      lane_q <= '0;
    end else begin
      word_q <= word_d;
      full_q <= full_d;
      lane_q <= lane_d;
    end
  end

endmodule

// File: rtl/pixel_serializer.sv
// rtl/pixel_serializer.sv - frame FSM, coordinates and ap handshakes; SERIALIZER_SOF_RESYNC_EN enables mid-frame SOF resync.
module pixel_serializer
  import pixel_serializer_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH  = 8,
  parameter int PIXELS_PER_BURST = 4,
  parameter int IN_COLS          = 16,
  parameter int IN_ROWS          = 8
) (
  input  logic                                                  clk,
  input  logic                                                  srst,
  input  logic                                                  ap_start,
  output logic                                                  ap_ready,
  output logic                                                  ap_idle,
  output logic                                                  ap_done,
  input  logic                                                  s_axis_tvalid,
  output logic                                                  s_axis_tready,
  input  logic [word_w(PIXEL_BIT_WIDTH, PIXELS_PER_BURST)-1:0]  s_axis_tdata,
  input  logic                                                  s_axis_tuser,
  output logic                                                  m_axis_tvalid,
  input  logic                                                  m_axis_tready,
  output logic [PIXEL_BIT_WIDTH-1:0]                            m_axis_tdata,
  output logic [col_w(IN_COLS)-1:0]                             cnt_col,
  output logic [row_w(IN_ROWS)-1:0]                             cnt_row,
  output logic                                                  sof_err
);

  localparam int COL_W       = col_w(IN_COLS);
  localparam int ROW_W       = row_w(IN_ROWS);
  localparam int TOTAL_WORDS = (IN_ROWS * IN_COLS) / PIXELS_PER_BURST;
  localparam int WCNT_W      = $clog2(TOTAL_WORDS + 1);
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(IN_COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(IN_ROWS - 1);
  localparam logic [WCNT_W-1:0] WORDS_FULL = WCNT_W'(TOTAL_WORDS);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              load, m_fire, wait_sof, stream_en, resync, last_pixel;

  assign wait_sof   = (state_q == WAIT_SOF);
  // Once the frame's last word is buffered, later words stay upstream for the next frame.
  assign stream_en  = (state_q == STREAM) && (wcnt_q != WORDS_FULL);
  assign last_pixel = (col_q == LAST_COL) && (row_q == LAST_ROW);

  burst_unpacker #(
    .PIXEL_BIT_WIDTH (PIXEL_BIT_WIDTH),
    .PIXELS_PER_BURST(PIXELS_PER_BURST)
  ) u_unpacker (
    .clk        (clk),
    .srst       (srst),
    .wait_sof_i (wait_sof),
    .stream_en_i(stream_en),
    .s_tvalid_i (s_axis_tvalid),
    .s_tdata_i  (s_axis_tdata),
    .s_tuser_i  (s_axis_tuser),
    .s_tready_o (s_axis_tready),
    .m_tvalid_o (m_axis_tvalid),
    .m_tready_i (m_axis_tready),
    .m_tdata_o  (m_axis_tdata),
    .load_o     (load),
    .m_fire_o   (m_fire)
  );

`ifdef SERIALIZER_SOF_RESYNC_EN
  logic sof_err_q, sof_err_d;
  assign resync    = (state_q == STREAM) && load && s_axis_tuser;
  assign sof_err_d = ((state_q == IDLE) && ap_start) ? 1'b0 : (sof_err_q || resync);
  always_ff @(posedge clk or posedge srst) begin
    if (srst) sof_err_q <= 1'b0;
    else      sof_err_q <= sof_err_d;
  end
  assign sof_err = sof_err_q;
`else
  assign resync  = 1'b0;
  assign sof_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          state_d = WAIT_SOF;
          col_d   = '0;
          row_d   = '0;
          wcnt_d  = '0;
        end
      end
      WAIT_SOF: begin
        if (load) begin
          state_d = STREAM;
          wcnt_d  = WCNT_W'(1);
        end
      end
      STREAM: begin
        if (m_fire) begin
          if (last_pixel) state_d = DONE;
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        // A resync word restarts the frame as its word 0 at (0,0).
        if (resync) begin
          col_d  = '0;
          row_d  = '0;
          wcnt_d = WCNT_W'(1);
        end else if (load) begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign ap_idle  = (state_q == IDLE);
  assign ap_ready = (state_q == IDLE);
  assign ap_done  = (state_q == DONE);
  assign cnt_col  = col_q;
  assign cnt_row  = row_q;

endmodule
